// File: rtl/tft_pkg.sv
// Shared constants and decoder state encoding for the TFT SPI monitor.
package tft_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CASET,
    ST_PASET,
    ST_RAMWR,
    ST_SKIP
  } dec_state_e;

endpackage

// File: rtl/tft_spi_rx.sv
// SPI mode-0 byte receiver: synchronises the wires into clk, detects
// rising edges of spi_clk and reassembles MSB-first bytes tagged with D/C.
module tft_spi_rx (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  input  logic       spi_dc,
  input  logic       spi_cs,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc
);

  logic [1:0] sclk_sync_q, mosi_sync_q, dc_sync_q, cs_sync_q;
  logic       sclk_prev_q;
  logic [6:0] shift_q;
  logic [2:0] bit_cnt_q;
  logic       byte_valid_q;
  logic [7:0] byte_data_q;
  logic       byte_dc_q;

  logic sclk_rise;
  logic last_bit;

  assign sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;
  assign last_bit  = (bit_cnt_q == 3'd7);

  // Two-flop synchronisers plus the previous synced clock for edge detection.
  // cs resets to its idle (deselected) level.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      sclk_sync_q <= 2'b00;
      mosi_sync_q <= 2'b00;
      dc_sync_q   <= 2'b00;
      cs_sync_q   <= 2'b11;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], spi_clk};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
      dc_sync_q   <= {dc_sync_q[0], spi_dc};
      cs_sync_q   <= {cs_sync_q[0], spi_cs};
      sclk_prev_q <= sclk_sync_q[1];
    end
  end

  // Shift register and bit counter; the 8th edge completes the byte even if
  // cs rises on that same edge. cs high otherwise drops any partial byte.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      byte_dc_q    <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      if (sclk_rise && (!cs_sync_q[1] || last_bit)) begin
        shift_q   <= {shift_q[5:0], mosi_sync_q[1]};
        bit_cnt_q <= bit_cnt_q + 3'd1;  // 7 -> 0 closes the byte
        if (last_bit) begin
          byte_valid_q <= 1'b1;
          byte_data_q  <= {shift_q, mosi_sync_q[1]};
          byte_dc_q    <= dc_sync_q[1];
        end
      end else if (cs_sync_q[1]) begin
        bit_cnt_q <= '0;
      end
    end
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign byte_dc    = byte_dc_q;

endmodule

// File: rtl/tft_spi_monitor.sv
// Passive TFT SPI display model: decodes CASET/PASET/RAMWR from the received
// byte stream into pixel-write events. COORD_W must lie in 9..16.
module tft_spi_monitor #(
  parameter int COORD_W = 9,
  parameter int X_LAST  = 239,
  parameter int Y_LAST  = 319
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               spi_clk,
  input  logic               spi_mosi,
  input  logic               spi_dc,
  input  logic               spi_cs,
  output logic               byte_valid,
  output logic [7:0]         byte_data,
  output logic               byte_dc,
  output logic               pix_valid,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic [15:0]        pix_color,
  output logic               frame_done
);

  import tft_pkg::*;

  localparam int HI_W = COORD_W - 8;
  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_dc;

  tft_spi_rx u_rx (
    .clk        (clk),
    .rst        (rst),
    .spi_clk    (spi_clk),
    .spi_mosi   (spi_mosi),
    .spi_dc     (spi_dc),
    .spi_cs     (spi_cs),
    .byte_valid (rx_valid),
    .byte_data  (rx_data),
    .byte_dc    (rx_dc)
  );

  dec_state_e          state_q, state_d;
  logic [1:0]          arg_idx_q, arg_idx_d;
  logic [HI_W-1:0]     start_hi_q, start_hi_d, end_hi_q, end_hi_d;
  logic [7:0]          start_lo_q, start_lo_d;
  logic [COORD_W-1:0]  xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
  logic [COORD_W-1:0]  x_q, x_d, y_q, y_d;
  logic                half_q, half_d;
  logic [7:0]          color_hi_q, color_hi_d;
  logic                pix_valid_q, pix_valid_d, frame_done_q, frame_done_d;
  logic [COORD_W-1:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [15:0]         pix_color_q, pix_color_d;

  // State, window, cursor and pixel output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      arg_idx_q    <= '0;
      start_hi_q   <= '0;
      start_lo_q   <= '0;
      end_hi_q     <= '0;
      xs_q         <= '0;
      xe_q         <= COORD_W'(X_LAST);
      ys_q         <= '0;
      ye_q         <= COORD_W'(Y_LAST);
      x_q          <= '0;
      y_q          <= '0;
      half_q       <= 1'b0;
      color_hi_q   <= '0;
      pix_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_color_q  <= '0;
    end else begin
      state_q      <= state_d;
      arg_idx_q    <= arg_idx_d;
      start_hi_q   <= start_hi_d;
      start_lo_q   <= start_lo_d;
      end_hi_q     <= end_hi_d;
      xs_q         <= xs_d;
      xe_q         <= xe_d;
      ys_q         <= ys_d;
      ye_q         <= ye_d;
      x_q          <= x_d;
      y_q          <= y_d;
      half_q       <= half_d;
      color_hi_q   <= color_hi_d;
      pix_valid_q  <= pix_valid_d;
      frame_done_q <= frame_done_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      pix_color_q  <= pix_color_d;
    end
  end

  // Decoder: commands select the state, data bytes fill arguments or pixels.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    state_d      = state_q;
    arg_idx_d    = arg_idx_q;
    start_hi_d   = start_hi_q;
    start_lo_d   = start_lo_q;
    end_hi_d     = end_hi_q;
    xs_d         = xs_q;
    xe_d         = xe_q;
    ys_d         = ys_q;
    ye_d         = ye_q;
    x_d          = x_q;
    y_d          = y_q;
    half_d       = half_q;
    color_hi_d   = color_hi_q;
    pix_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    pix_color_d  = pix_color_q;

    if (rx_valid) begin
      if (!rx_dc) begin
        arg_idx_d = '0;
        half_d    = 1'b0;
        case (rx_data)
          CMD_CASET: state_d = ST_CASET;
          CMD_PASET: state_d = ST_PASET;
          CMD_RAMWR: begin
            state_d = ST_RAMWR;
            x_d     = xs_q;
            y_d     = ys_q;
          end
          default:   state_d = ST_SKIP;
        endcase
      end else begin
        case (state_q)
          ST_CASET, ST_PASET: begin
            arg_idx_d = arg_idx_q + 2'd1;
            case (arg_idx_q)
              2'd0: start_hi_d = rx_data[HI_W-1:0];
              2'd1: start_lo_d = rx_data;
              2'd2: end_hi_d   = rx_data[HI_W-1:0];
              default: begin
                // Start and end commit together, only on the final argument.
                if (state_q == ST_CASET) begin
                  xs_d = {start_hi_q, start_lo_q};
                  xe_d = {end_hi_q, rx_data};
                end else begin
                  ys_d = {start_hi_q, start_lo_q};
                  ye_d = {end_hi_q, rx_data};
                end
                state_d = ST_SKIP;
              end
            endcase
          end
          ST_RAMWR: begin
            if (!half_q) begin
              color_hi_d = rx_data;
              half_d     = 1'b1;
            end else begin
              half_d       = 1'b0;
              pix_valid_d  = 1'b1;
              pix_x_d      = x_q;
              pix_y_d      = y_q;
              pix_color_d  = {color_hi_q, rx_data};
              frame_done_d = (x_q == xe_q) && (y_q == ye_q);
              if (x_q == xe_q) begin
                x_d = xs_q;
                y_d = (y_q == ye_q) ? ys_q : y_q + ONE;
              end else begin
                x_d = x_q + ONE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign byte_valid = rx_valid;
  assign byte_data  = rx_data;
  assign byte_dc    = rx_dc;
  assign pix_valid  = pix_valid_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign pix_color  = pix_color_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_tft_spi_monitor.sv
// Self-checking bench for tft_spi_monitor: directed scenarios with literal
// expectations plus randomized SPI traffic checked against a display model.
module tb_tft_spi_monitor;

  localparam int COORD_W = 9;
  localparam int M       = 1 << COORD_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic spi_clk = 1'b0, spi_mosi = 1'b0, spi_dc = 1'b0, spi_cs = 1'b1;
  logic               byte_valid;
  logic [7:0]         byte_data;
  logic               byte_dc;
  logic               pix_valid;
  logic [COORD_W-1:0] pix_x, pix_y;
  logic [15:0]        pix_color;
  logic               frame_done;

  tft_spi_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .spi_clk    (spi_clk),
    .spi_mosi   (spi_mosi),
    .spi_dc     (spi_dc),
    .spi_cs     (spi_cs),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_dc    (byte_dc),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_color  (pix_color),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- display model ----------------
  typedef struct { bit dc; bit [7:0] data; bit pix; } exp_byte_t;
  typedef struct { int x; int y; int color; bit fd; } exp_pix_t;

  exp_byte_t byte_q[$];
  exp_pix_t  pix_q[$];
  exp_pix_t  obs_pix[$];
  int        obs_bytes = 0;
  bit [7:0]  last_byte;

  string     mode;
  int        xs, xe, ys, ye, cx, cy, argn;
  bit [7:0]  args[4];
  bit        have_hi;
  bit [7:0]  hi_byte;

  task automatic model_reset();
    xs = 0; xe = 239; ys = 0; ye = 319; cx = 0; cy = 0;
    mode = "idle"; argn = 0; have_hi = 0;
    byte_q.delete();
    pix_q.delete();
  endtask

  task automatic model_byte(input bit dc, input bit [7:0] d);
    exp_byte_t b;
    exp_pix_t  p;
    int s, e;
    b.dc = dc; b.data = d; b.pix = 0;
    if (!dc) begin
      argn = 0; have_hi = 0;
      if (d == 8'h2A) mode = "caset";
      else if (d == 8'h2B) mode = "paset";
      else if (d == 8'h2C) begin mode = "ramwr"; cx = xs; cy = ys; end
      else mode = "skip";
    end else if (mode == "caset" || mode == "paset") begin
      args[argn] = d;
      argn++;
      if (argn == 4) begin
        s = (int'(args[0]) * 256 + int'(args[1])) % M;
        e = (int'(args[2]) * 256 + int'(args[3])) % M;
        if (mode == "caset") begin xs = s; xe = e; end
        else begin ys = s; ye = e; end
        mode = "skip";
      end
    end else if (mode == "ramwr") begin
      if (!have_hi) begin
        hi_byte = d; have_hi = 1;
      end else begin
        have_hi = 0;
        p.x = cx; p.y = cy; p.color = int'(hi_byte) * 256 + int'(d);
        p.fd = (cx == xe) && (cy == ye);
        pix_q.push_back(p);
        b.pix = 1;
        if (cx == xe) begin
          cx = xs;
          cy = (cy == ye) ? ys : (cy + 1) % M;
        end else begin
          cx = (cx + 1) % M;
        end
      end
    end
    byte_q.push_back(b);
  endtask

  // ---------------- compare process ----------------
  bit        pend_pix = 0;
  exp_byte_t cmp_b;
  exp_pix_t  cmp_e, cmp_o;

  always @(negedge clk) begin
    if (!rst) begin
      pend_pix = 0;
    end else begin
      if (pix_valid || pend_pix) check("pix_timing", pix_valid, pend_pix);
      if (frame_done) check("frame_done_without_pix", !pix_valid, 0);
      if (pix_valid) begin
        cmp_o.x = int'(pix_x); cmp_o.y = int'(pix_y);
        cmp_o.color = int'(pix_color); cmp_o.fd = frame_done;
        obs_pix.push_back(cmp_o);
        if (pend_pix && pix_q.size() != 0) begin
          cmp_e = pix_q.pop_front();
          check("pix_x", pix_x, cmp_e.x);
          check("pix_y", pix_y, cmp_e.y);
          check("pix_color", pix_color, cmp_e.color);
          check("frame_done", frame_done, cmp_e.fd);
        end
      end
      pend_pix = 0;
      if (byte_valid) begin
        obs_bytes++;
        last_byte = byte_data;
        check("byte_expected", byte_q.size() != 0, 1);
        if (byte_q.size() != 0) begin
          cmp_b = byte_q.pop_front();
          check("byte_data", byte_data, cmp_b.data);
          check("byte_dc", byte_dc, cmp_b.dc);
          pend_pix = cmp_b.pix;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_bits(input bit [7:0] d, input int n, input bit dc, input bit cs_last);
    spi_cs = 1'b0;
    spi_dc = dc;
    for (int i = 0; i < n; i++) begin
      spi_mosi = d[7-i];
      #40;
      spi_clk = 1'b1;
      if (cs_last && i == n - 1) spi_cs = 1'b1;
      #40;
      spi_clk = 1'b0;
    end
  endtask

  task automatic send_byte(input bit dc, input bit [7:0] d, input bit cs_last = 1'b0);
    model_byte(dc, d);
    send_bits(d, 8, dc, cs_last);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_byte_outs", {byte_valid, byte_data, byte_dc}, 0);
    check("reset_pix_outs", {pix_valid, pix_x, pix_y, frame_done}, 0);
    check("reset_pix_color", pix_color, 0);
    model_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while ((byte_q.size() != 0 || pix_q.size() != 0 || pend_pix) && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("drain_bytes", byte_q.size(), 0);
    check("drain_pix", pix_q.size(), 0);
  endtask

  task automatic check_pix(input string name, input int idx, input int x, input int y,
                           input int color, input bit fd);
    check({name, "_present"}, obs_pix.size() > idx, 1);
    if (obs_pix.size() > idx) begin
      check({name, "_x"}, obs_pix[idx].x, x);
      check({name, "_y"}, obs_pix[idx].y, y);
      check({name, "_color"}, obs_pix[idx].color, color);
      check({name, "_fd"}, obs_pix[idx].fd, fd);
    end
  endtask

  // ---------------- test sequence ----------------
  int b0, p0, r, k;
  bit [7:0] d;
  int exp_x[5] = '{10, 11, 10, 11, 10};
  int exp_y[5] = '{20, 20, 21, 21, 20};

  initial begin
    @(negedge clk);
    apply_reset();

    // 1: single pixel after RAMWR
    b0 = obs_bytes; p0 = obs_pix.size();
    send_byte(0, 8'h2C); send_byte(1, 8'hF8); send_byte(1, 8'h00);
    drain();
    check("t1_bytes", obs_bytes - b0, 3);
    check("t1_pix_count", obs_pix.size() - p0, 1);
    check_pix("t1_pix", p0, 0, 0, 16'hF800, 0);

    // 2: 2x2 window, wrap back to origin
    apply_reset();
    p0 = obs_pix.size();
    send_byte(0, 8'h2A); send_byte(1, 8'h00); send_byte(1, 8'h0A); send_byte(1, 8'h00); send_byte(1, 8'h0B);
    send_byte(0, 8'h2B); send_byte(1, 8'h00); send_byte(1, 8'h14); send_byte(1, 8'h00); send_byte(1, 8'h15);
    send_byte(0, 8'h2C);
    for (int i = 0; i < 5; i++) begin
      send_byte(1, 8'hA0); send_byte(1, 8'(i));
    end
    drain();
    check("t2_pix_count", obs_pix.size() - p0, 5);
    for (int i = 0; i < 5; i++)
      check_pix("t2_pix", p0 + i, exp_x[i], exp_y[i], 16'hA000 + i, i == 3);

    // 3: aborted CASET leaves the default window
    apply_reset();
    p0 = obs_pix.size();
    send_byte(0, 8'h2A); send_byte(1, 8'h00); send_byte(1, 8'h05);
    send_byte(0, 8'h2C);
    for (int i = 0; i < 7; i++) begin
      send_byte(1, 8'h00); send_byte(1, 8'(i));
    end
    drain();
    check_pix("t3_first", p0, 0, 0, 0, 0);
    check_pix("t3_seventh", p0 + 6, 6, 0, 6, 0);

    // 4: partial byte dropped by cs high
    apply_reset();
    b0 = obs_bytes;
    send_bits(8'hFF, 5, 0, 0);
    spi_cs = 1'b1; #80;
    send_byte(0, 8'h2C);
    drain();
    check("t4_bytes", obs_bytes - b0, 1);
    check("t4_byte", last_byte, 8'h2C);

    // 5: half pixel discarded by an intervening command
    apply_reset();
    p0 = obs_pix.size();
    send_byte(0, 8'h2C); send_byte(1, 8'hAB); send_byte(0, 8'h00);
    send_byte(0, 8'h2C); send_byte(1, 8'h12); send_byte(1, 8'h34);
    drain();
    check("t5_pix_count", obs_pix.size() - p0, 1);
    check_pix("t5_pix", p0, 0, 0, 16'h1234, 0);

    // cs rising together with the 8th clock edge still completes the byte
    apply_reset();
    b0 = obs_bytes; p0 = obs_pix.size();
    send_byte(0, 8'h2C, 1); send_byte(1, 8'h55, 1); send_byte(1, 8'hAA, 1);
    drain();
    check("tcs_bytes", obs_bytes - b0, 3);
    check_pix("tcs_pix", p0, 0, 0, 16'h55AA, 0);

    // 6: reset mid-RAMWR and mid-byte
    apply_reset();
    send_byte(0, 8'h2A); send_byte(1, 8'h00); send_byte(1, 8'h03); send_byte(1, 8'h00); send_byte(1, 8'h09);
    send_byte(0, 8'h2C); send_byte(1, 8'hF0); send_byte(1, 8'h0F);
    send_byte(1, 8'h11);
    drain();
    check("t6_pre_x", pix_x, 3);
    send_bits(8'hC3, 4, 1, 0);
    apply_reset();
    b0 = obs_bytes; p0 = obs_pix.size();
    send_byte(1, 8'h22); send_byte(1, 8'h33);
    drain();
    check("t6_bytes", obs_bytes - b0, 2);
    check("t6_byte", last_byte, 8'h33);
    check("t6_pix_count", obs_pix.size() - p0, 0);

    // randomized traffic against the model
    apply_reset();
    for (int n = 0; n < 350; n++) begin
      r = $urandom_range(0, 99);
      if (r < 6) begin
        send_bits(8'($urandom), $urandom_range(1, 7), 1'($urandom_range(0, 1)), 0);
        spi_cs = 1'b1; #80;
      end else if (r < 10) begin
        spi_cs = 1'b1; #80;
      end else if (r < 30) begin
        k = $urandom_range(0, 4);
        d = (k == 0) ? 8'h2A : (k == 1) ? 8'h2B : (k < 4) ? 8'h2C : 8'($urandom);
        send_byte(0, d, $urandom_range(0, 9) == 0);
      end else begin
        if (mode == "caset" || mode == "paset") begin
          if (argn % 2 == 0) d = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h00;
          else d = 8'($urandom_range(0, 5));
        end else begin
          d = 8'($urandom);
        end
        send_byte(1, d, $urandom_range(0, 9) == 0);
      end
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
